lsu_queue: RTL and testbench
============================

LSU_QUEUE -- requirements
Module: lsu_queue

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit, clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-006 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_write (in, 1; 1=store, 0=load), req_addr (in, ADDR_BITS) and req_wdata (in, DATA_BITS): the core-side request channel.
REQ-007 SHALL have ports resp_valid (out, 1) and resp_data (out, DATA_BITS): load responses.
REQ-008 SHALL have ports mem_read_valid (out, 1), mem_read_address (out, ADDR_BITS), mem_read_ready (in, 1) and mem_read_data (in, DATA_BITS): one consumer slot of the data cache.
REQ-009 SHALL have ports mem_write_valid (out, 1), mem_write_address (out, ADDR_BITS), mem_write_data (out, DATA_BITS) and mem_write_ready (in, 1): the cache write slot.
REQ-010 SHALL have ports occupancy (out, $clog2(DEPTH)+1) and idle (out, 1; high when the queue is empty and the FSM is in IDLE).
REQ-011 SHALL have ports perf_reads (out, 16), perf_writes (out, 16) and perf_stalls (out, 16).

Function
REQ-012 SHALL accept a request on any edge where req_valid and req_ready are both high, writing {write, addr, wdata} at the tail of a circular FIFO.
REQ-013 SHALL drive req_ready combinationally as occupancy < DEPTH.
REQ-014 SHALL allow push and pop in the same cycle; occupancy is then unchanged.
REQ-015 SHALL wrap head and tail pointers modulo DEPTH.
REQ-016 SHALL implement FSM states IDLE, ISSUE and RELEASE.
REQ-017 SHALL in IDLE with the queue non-empty: register the head entry onto the mem address/data outputs, assert mem_read_valid (load) or mem_write_valid (store), and go to ISSUE.
REQ-018 SHALL in IDLE with the queue empty: stay in IDLE and drive both mem valids low.
REQ-019 SHALL issue a request accepted into an empty queue in IDLE with its mem valid high on the next edge (latency 1).
REQ-020 SHALL in ISSUE hold valid, address and data stable until the matching ready is sampled high.
REQ-021 SHALL on that edge: drop valid, pop the head entry and go to RELEASE.
REQ-022 SHALL for a load on that same edge: set resp_data = mem_read_data and pulse resp_valid high for exactly one cycle.
REQ-023 SHALL in RELEASE wait until the matching ready is sampled low, then go to IDLE; no new valid is raised while the previous ready is still high.
REQ-024 SHALL return responses in request order, one at a time, with no more than one mem request outstanding.
REQ-025 SHALL never assert mem_read_valid and mem_write_valid simultaneously.
REQ-026 SHALL ignore a ready input whose request is not outstanding, including ready during IDLE.

Reset
REQ-027 SHALL on reset set every output register to 0: mem valids, addresses, write data, resp_valid, resp_data and perf counters.
REQ-028 SHALL on reset empty the queue (pointers 0, occupancy 0) and set the FSM to IDLE.
REQ-029 SHALL on reset mid-operation discard queued and outstanding requests; no resp_valid pulse is produced for them.
REQ-030 SHALL make reset take priority over a simultaneous push or ready.

Configuration
REQ-031 SHALL use macro LSU_QUEUE_PERF_EN.
REQ-032 SHALL when LSU_QUEUE_PERF_EN is defined, count completed loads in perf_reads and completed stores in perf_writes.
REQ-033 SHALL when LSU_QUEUE_PERF_EN is defined, count in perf_stalls the cycles spent in ISSUE with ready low.
REQ-034 SHALL wrap all three perf counters modulo 2^16.
REQ-035 SHALL when LSU_QUEUE_PERF_EN is undefined, tie perf_reads, perf_writes and perf_stalls to constant 0 with no counter logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover single load: push load addr 0x12 into an empty queue; mem_read_ready high 3 cycles after valid returning data 0xA5 -> mem_read_valid next edge, addr 0x12, resp_valid one cycle with resp_data 0xA5, idle after ready drops.
REQ-037 SHALL cover store then load: push store 0x20/0x5C then load 0x20 back-to-back -> write issued first with data 0x5C; read valid rises only after mem_write_ready is seen low.
REQ-038 SHALL cover full queue: push 4 requests with ready held low -> req_ready low and occupancy 4; a 5th push is not accepted; after one completion, a push and pop in the same cycle keep occupancy 3.
REQ-039 SHALL cover wrap-around: stream 10 loads with addresses 0..9 -> 10 responses in order with data matching each address.
REQ-040 SHALL cover reset mid-ISSUE: assert reset while a load is waiting -> next edge shows all valids 0, occupancy 0, no resp_valid.
REQ-041 SHALL cover performance counters with LSU_QUEUE_PERF_EN defined: 3 loads, 2 stores, 7 ready-low ISSUE cycles -> perf_reads 3, perf_writes 2, perf_stalls 7; without the macro all three are 0.

Source files
------------

// File: rtl/lsu_queue_if.sv
// rtl/lsu_queue_if.sv - core request, load response and data-cache slot bundle for lsu_queue
interface lsu_queue_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;

    logic                 resp_valid;
    logic [DATA_BITS-1:0] resp_data;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    // Core and cache side: drives requests and readies, observes the queue.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

    // Queue side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_data,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );
endinterface

// File: rtl/lsu_queue.sv
// rtl/lsu_queue.sv - in-order load/store queue with one outstanding cache request; LSU_QUEUE_PERF_EN enables perf counters
module lsu_queue #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    lsu_queue_if.slave               bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     idle,
    output logic [15:0]              perf_reads,
    output logic [15:0]              perf_writes,
    output logic [15:0]              perf_stalls
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic                 r_q_write [DEPTH];
    logic [ADDR_BITS-1:0] r_q_addr  [DEPTH];
    logic [DATA_BITS-1:0] r_q_data  [DEPTH];

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W:0]       r_count;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_is_write;

    logic                 r_mem_read_valid;
    logic [ADDR_BITS-1:0] r_mem_read_address;
    logic                 r_mem_write_valid;
    logic [ADDR_BITS-1:0] r_mem_write_address;
    logic [DATA_BITS-1:0] r_mem_write_data;
    logic                 r_resp_valid;
    logic [DATA_BITS-1:0] r_resp_data;

    logic                 w_req_ready;
    logic                 w_push;
    logic                 w_ready;
    logic                 w_launch;
    logic                 w_done;

    assign w_req_ready = (r_count < FULL_COUNT);
    assign w_push      = bus.req_valid && w_req_ready;
    // Only the ready belonging to the outstanding request's type is ever looked at.
    assign w_ready     = r_is_write ? bus.mem_write_ready : bus.mem_read_ready;

    assign bus.req_ready         = w_req_ready;
    assign bus.resp_valid        = r_resp_valid;
    assign bus.resp_data         = r_resp_data;
    assign bus.mem_read_valid    = r_mem_read_valid;
    assign bus.mem_read_address  = r_mem_read_address;
    assign bus.mem_write_valid   = r_mem_write_valid;
    assign bus.mem_write_address = r_mem_write_address;
    assign bus.mem_write_data    = r_mem_write_data;

    assign occupancy = r_count;
    assign idle      = (r_count == '0) && (r_state == IDLE);

    // Queue storage: written at the tail on every accepted request.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_write[r_tail] <= bus.req_write;
            r_q_addr[r_tail]  <= bus.req_addr;
            r_q_data[r_tail]  <= bus.req_wdata;
        end
    end

    // Pointers and occupancy; the head entry stays queued until its cache handshake completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_done) r_head <= r_head + 1'b1;
            case ({w_push, w_done})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state: launch from IDLE, complete in ISSUE, wait for ready to fall in RELEASE.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_launch     = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_ready) begin
                    w_done       = 1'b1;
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Cache-side and response output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_write          <= 1'b0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_resp_valid        <= 1'b0;
            r_resp_data         <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_launch) begin
                r_is_write <= r_q_write[r_head];
                if (r_q_write[r_head]) begin
                    r_mem_write_valid   <= 1'b1;
                    r_mem_write_address <= r_q_addr[r_head];
                    r_mem_write_data    <= r_q_data[r_head];
                end else begin
                    r_mem_read_valid    <= 1'b1;
                    r_mem_read_address  <= r_q_addr[r_head];
                end
            end
            if (w_done) begin
                r_mem_read_valid  <= 1'b0;
                r_mem_write_valid <= 1'b0;
                if (!r_is_write) begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= bus.mem_read_data;
                end
            end
        end
    end

`ifdef LSU_QUEUE_PERF_EN
    logic [15:0] r_perf_reads;
    logic [15:0] r_perf_writes;
    logic [15:0] r_perf_stalls;

    // Completion and stall counters, free-running modulo 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_done && !r_is_write) r_perf_reads  <= r_perf_reads + 16'd1;
            if (w_done &&  r_is_write) r_perf_writes <= r_perf_writes + 16'd1;
            if ((r_state == ISSUE) && !w_ready) r_perf_stalls <= r_perf_stalls + 16'd1;
        end
    end

    assign perf_reads  = r_perf_reads;
    assign perf_writes = r_perf_writes;
    assign perf_stalls = r_perf_stalls;
`else
    assign perf_reads  = 16'd0;
    assign perf_writes = 16'd0;
    assign perf_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_lsu_queue.sv
// tb/tb_lsu_queue.sv - directed self-checking bench for lsu_queue
module tb_lsu_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  occupancy;
    logic        idle;
    logic [15:0] perf_reads;
    logic [15:0] perf_writes;
    logic [15:0] perf_stalls;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_queue_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();

    lsu_queue #(.ADDR_BITS(8), .DATA_BITS(8), .DEPTH(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .occupancy   (occupancy),
        .idle        (idle),
        .perf_reads  (perf_reads),
        .perf_writes (perf_writes),
        .perf_stalls (perf_stalls)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction: push, launch, hold ready low for 'stalls' cycles, complete, release.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd, input int stalls);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("txn_rd_valid", {31'd0, bus.mem_read_valid}, {31'd0, ~w});
        chk("txn_wr_valid", {31'd0, bus.mem_write_valid}, {31'd0, w});
        chk("txn_addr", {24'd0, (w ? bus.mem_write_address : bus.mem_read_address)}, {24'd0, a});
        repeat (stalls) tick();
        bus.mem_read_data = rd;
        if (w) bus.mem_write_ready = 1'b1;
        else   bus.mem_read_ready  = 1'b1;
        tick();
        chk("txn_resp_valid", {31'd0, bus.resp_valid}, {31'd0, ~w});
        if (!w) chk("txn_resp_data", {24'd0, bus.resp_data}, {24'd0, rd});
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        tick();
        chk("txn_idle", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        int  sent;
        int  got;
        logic acc;

        reset               = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_write       = 1'b0;
        bus.req_addr        = 8'h00;
        bus.req_wdata       = 8'h00;
        bus.mem_read_ready  = 1'b0;
        bus.mem_read_data   = 8'h00;
        bus.mem_write_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_rd_valid", {31'd0, bus.mem_read_valid}, 32'd0);
        chk("rst_wr_valid", {31'd0, bus.mem_write_valid}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_rd_addr", {24'd0, bus.mem_read_address}, 32'd0);
        chk("rst_perf_reads", {16'd0, perf_reads}, 32'd0);
        reset = 1'b0;

        // Single load, ready 3 cycles after valid
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h12;
        tick();
        bus.req_valid = 1'b0;
        chk("ld_occupancy", {29'd0, occupancy}, 32'd1);
        chk("ld_valid_pre", {31'd0, bus.mem_read_valid}, 32'd0);
        tick();
        chk("ld_valid", {31'd0, bus.mem_read_valid}, 32'd1);
        chk("ld_addr", {24'd0, bus.mem_read_address}, 32'h12);
        chk("ld_wr_valid", {31'd0, bus.mem_write_valid}, 32'd0);
        tick();
        tick();
        chk("ld_hold_valid", {31'd0, bus.mem_read_valid}, 32'd1);
        chk("ld_hold_addr", {24'd0, bus.mem_read_address}, 32'h12);
        chk("ld_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'hA5;
        tick();
        chk("ld_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("ld_resp_data", {24'd0, bus.resp_data}, 32'hA5);
        chk("ld_valid_drop", {31'd0, bus.mem_read_valid}, 32'd0);
        chk("ld_occ_after", {29'd0, occupancy}, 32'd0);
        chk("ld_not_idle", {31'd0, idle}, 32'd0);
        tick();
        chk("ld_resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
        chk("ld_release_idle", {31'd0, idle}, 32'd0);
        bus.mem_read_ready = 1'b0;
        tick();
        chk("ld_idle", {31'd0, idle}, 32'd1);

        // Store then load back-to-back
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 8'h5C;
        tick();
        bus.req_write = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("st_wr_valid", {31'd0, bus.mem_write_valid}, 32'd1);
        chk("st_wr_addr", {24'd0, bus.mem_write_address}, 32'h20);
        chk("st_wr_data", {24'd0, bus.mem_write_data}, 32'h5C);
        chk("st_rd_valid", {31'd0, bus.mem_read_valid}, 32'd0);
        chk("st_occupancy", {29'd0, occupancy}, 32'd2);
        bus.mem_write_ready = 1'b1;
        tick();
        chk("st_wr_drop", {31'd0, bus.mem_write_valid}, 32'd0);
        chk("st_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("st_occ_after", {29'd0, occupancy}, 32'd1);
        tick();
        chk("st_rd_wait_ready", {31'd0, bus.mem_read_valid}, 32'd0);
        bus.mem_write_ready = 1'b0;
        tick();
        chk("st_rd_release", {31'd0, bus.mem_read_valid}, 32'd0);
        tick();
        chk("st_rd_valid_late", {31'd0, bus.mem_read_valid}, 32'd1);
        chk("st_rd_addr", {24'd0, bus.mem_read_address}, 32'h20);
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'h77;
        tick();
        chk("st_ld_resp", {24'd0, bus.resp_data}, 32'h77);
        bus.mem_read_ready = 1'b0;
        tick();
        chk("st_idle", {31'd0, idle}, 32'd1);

        // Wrap-around: ten streamed loads, memory returns address ^ 0x5A
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            bus.req_valid      = (sent < 10);
            bus.req_write      = 1'b0;
            bus.req_addr       = 8'(sent);
            bus.mem_read_ready = bus.mem_read_valid;
            bus.mem_read_data  = bus.mem_read_address ^ 8'h5A;
            acc = bus.req_valid && bus.req_ready;
            tick();
            if (acc) sent++;
            if (bus.resp_valid) begin
                chk("wrap_resp", {24'd0, bus.resp_data}, {24'd0, 8'(got) ^ 8'h5A});
                got++;
            end
        end
        bus.req_valid = 1'b0;
        chk("wrap_count", got, 32'd10);
        bus.mem_read_ready = 1'b0;
        tick();
        chk("wrap_idle", {31'd0, idle}, 32'd1);

        // Full queue with ready held low
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 8'h30 + 8'(i);
            tick();
        end
        bus.req_addr = 8'h34;
        chk("full_occupancy", {29'd0, occupancy}, 32'd4);
        chk("full_req_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk("full_no_push", {29'd0, occupancy}, 32'd4);
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'hB0;
        tick();
        chk("full_resp", {24'd0, bus.resp_data}, 32'hB0);
        chk("full_occ_pop", {29'd0, occupancy}, 32'd3);
        bus.req_valid      = 1'b0;
        bus.mem_read_ready = 1'b0;
        tick();
        tick();
        chk("full_next_addr", {24'd0, bus.mem_read_address}, 32'h31);
        chk("full_next_valid", {31'd0, bus.mem_read_valid}, 32'd1);
        bus.req_valid      = 1'b1;
        bus.req_addr       = 8'h34;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'hB1;
        tick();
        chk("full_push_pop_occ", {29'd0, occupancy}, 32'd3);
        chk("full_push_pop_resp", {24'd0, bus.resp_data}, 32'hB1);
        bus.req_valid      = 1'b0;
        bus.mem_read_ready = 1'b0;
        tick();
        tick();
        chk("mid_valid", {31'd0, bus.mem_read_valid}, 32'd1);
        chk("mid_addr", {24'd0, bus.mem_read_address}, 32'h32);

        // Reset while a load waits in ISSUE, with a simultaneous push and ready
        reset              = 1'b1;
        bus.req_valid      = 1'b1;
        bus.req_addr       = 8'h35;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'hEE;
        tick();
        chk("rmid_rd_valid", {31'd0, bus.mem_read_valid}, 32'd0);
        chk("rmid_wr_valid", {31'd0, bus.mem_write_valid}, 32'd0);
        chk("rmid_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rmid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        reset              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.mem_read_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmid_quiet_resp", {31'd0, bus.resp_valid}, 32'd0);
            chk("rmid_quiet_valid", {31'd0, bus.mem_read_valid}, 32'd0);
        end
        chk("rmid_idle", {31'd0, idle}, 32'd1);

        // Performance scenario: 3 loads, 2 stores, 2+1+0+1+3 = 7 stall cycles
        do_txn(1'b0, 8'h40, 8'h00, 8'hC0, 2);
        do_txn(1'b1, 8'h41, 8'h11, 8'h00, 1);
        do_txn(1'b0, 8'h42, 8'h00, 8'hC2, 0);
        do_txn(1'b1, 8'h43, 8'h33, 8'h00, 1);
        do_txn(1'b0, 8'h44, 8'h00, 8'hC4, 3);
`ifdef LSU_QUEUE_PERF_EN
        chk("perf_reads", {16'd0, perf_reads}, 32'd3);
        chk("perf_writes", {16'd0, perf_writes}, 32'd2);
        chk("perf_stalls", {16'd0, perf_stalls}, 32'd7);
`else
        chk("perf_reads", {16'd0, perf_reads}, 32'd0);
        chk("perf_writes", {16'd0, perf_writes}, 32'd0);
        chk("perf_stalls", {16'd0, perf_stalls}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
